// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the register bank.
// Holds the init/run state enum and default geometry.
package reg_bank_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NREAD_DEF  = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_if.sv
// Register bank bus: read ports, write port, scoreboard set, ready.
// master = decode/writeback side, slave = reg_bank.
interface reg_bank_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);

  logic                    ready;
  logic                    re;
  logic [NREAD*ADDR_W-1:0] ra;
  logic [NREAD*WIDTH-1:0]  rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    we;
  logic [ADDR_W-1:0]       wa;
  logic [WIDTH-1:0]        wd;
  logic                    sb_set;
  logic [ADDR_W-1:0]       sb_addr;

  modport master (
    input  ready, rd_data, rd_busy,
    output re, ra, we, wa, wd, sb_set, sb_addr
  );

  modport slave (
    output ready, rd_data, rd_busy,
    input  re, ra, we, wa, wd, sb_set, sb_addr
  );

endinterface

// File: rtl/reg_bank_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback.
// Ports: clk, rst, en, set/clr requests, ra lookups -> busy_o.
module reg_bank_scoreboard
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    set_i,
  input  logic [ADDR_W-1:0]       set_addr_i,
  input  logic                    clr_i,
  input  logic [ADDR_W-1:0]       clr_addr_i,
  input  logic [NREAD*ADDR_W-1:0] ra_i,
  output logic [NREAD-1:0]        busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             set_ok;

  assign set_ok = set_i &&
    !(ZERO_REG && (set_addr_i == '0));

  // Set is applied after clear so it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (en && clr_i)
      busy_d[clr_addr_i] = 1'b0;
    if (en && set_ok)
      busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NREAD; i++)
      busy_o[i] = en &
        busy_q[ra_i[i*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/reg_bank.sv
// Parametrised register bank with init sweep and busy scoreboard.
// Ports: clk, rst, bus (slave). Macro REG_BANK_BYPASS_EN = write-first.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input logic     clk,
  input logic     rst,
  reg_bank_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic [NREAD*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_wa;
  logic [WIDTH-1:0]       mem_wd;
  logic                   zero_wa;
  logic                   run_we;

  assign zero_wa = ZERO_REG && (bus.wa == '0);
  assign run_we  = ready_q && bus.we && !zero_wa;

  // Init sweep owns the write port until RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = bus.wa;
    mem_wd  = bus.wd;
    unique case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = run_we;
      end
    endcase
    ready_d = (state_q == ST_RUN);
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (ready_q && bus.re) begin
      for (int i = 0; i < NREAD; i++) begin
        if (ZERO_REG &&
            bus.ra[i*ADDR_W +: ADDR_W] == '0)
          rd_data_d[i*WIDTH +: WIDTH] = '0;
`ifdef REG_BANK_BYPASS_EN
        else if (run_we &&
                 bus.ra[i*ADDR_W +: ADDR_W] == bus.wa)
          rd_data_d[i*WIDTH +: WIDTH] = bus.wd;
`endif
        else
          rd_data_d[i*WIDTH +: WIDTH] =
            mem_q[bus.ra[i*ADDR_W +: ADDR_W]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem_q[mem_wa] <= mem_wd;
  end

  reg_bank_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .en         (ready_q),
    .set_i      (bus.sb_set),
    .set_addr_i (bus.sb_addr),
    .clr_i      (bus.we),
    .clr_addr_i (bus.wa),
    .ra_i       (bus.ra),
    .busy_o     (bus.rd_busy)
  );

  assign bus.ready   = ready_q;
  assign bus.rd_data = rd_data_q;

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised register bank, successor to the single-issue 32×32 register file. Generalised in data width, depth, and read-port count. Adds:
- simultaneous read and write in one cycle;
- a self-clearing init sequence after reset;
- a per-register busy scoreboard for pipeline hazard detection.

It sits between decode (read/issue) and writeback (write/clear) in the CPU datapath.

## Interface

Parameters:
- WIDTH, 32, data bits per register
- ADDR_W, 5, address bits; DEPTH = 2**ADDR_W registers
- NREAD, 2, number of read ports
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes, is never busy

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ready  out  1  high once init sweep is complete
- re  in  1  read enable, all ports
- ra  in  NREAD*ADDR_W  read addresses; port i = ra[i*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*WIDTH  registered read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  out  NREAD  combinational busy bit of the register currently on ra[i]
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  WIDTH  write data
- sb_set  in  1  mark register sb_addr busy (instruction issued with that destination)
- sb_addr  in  ADDR_W  scoreboard set address

## Operation

- FSM states:
  - INIT: entered on rst. An ADDR_W-bit counter writes 0 to entry cnt each cycle, counting 0..DEPTH-1. After writing DEPTH-1 the FSM moves to RUN.
  - RUN: ready=1. Stays in RUN until rst.
- While ready=0, re, we and sb_set are ignored and rd_busy is all zero.
- Write (RUN, we=1): array[wa] <= wd. Also clears busy[wa]. When ZERO_REG=1 and wa=0, the write is dropped.
- Read (RUN, re=1): rd_data[i] <= array[ra[i]] for every port. When ZERO_REG=1 and ra[i]=0, the port returns 0. When re=0, rd_data holds its value.
- Duplicate read addresses across ports are legal; the ports return identical data.
- Read and write in the same cycle are both accepted. Same-address handling depends on REG_BANK_BYPASS_EN (see Configuration).
- Scoreboard: busy[sb_addr] <= 1 on sb_set.
  - sb_set and a we clear hitting the same address in the same cycle: set wins, and busy ends at 1.
  - ZERO_REG=1: sb_set to address 0 is ignored.
- rd_busy[i] = busy[ra[i]]. It reflects registered state and does not include a same-cycle sb_set or we clear.

## Timing

- Reset values: ready=0, rd_data=0, busy all 0, FSM=INIT, cnt=0.
- Init takes DEPTH cycles after rst deasserts. With the default DEPTH=32, ready rises on the 33rd rising edge after the first edge that samples rst=0.
- Read latency is 1 cycle: address on edge N, data valid after edge N.
- Write is visible to a read issued on the next cycle. Same-cycle visibility is governed by the bypass macro.
- rst asserted mid-operation: next edge returns to INIT, clears busy and rd_data, and restarts the sweep. Array contents are not guaranteed until ready=1.

## Configuration

- REG_BANK_BYPASS_EN defined: on same-cycle re and we with ra[i]==wa (and not the zero register), rd_data[i] receives wd (write-first).
- Not defined: rd_data[i] receives the pre-write array value (read-first). The write still completes.

## Structure

- Package reg_bank_pkg holds:
  - state enum {ST_INIT, ST_RUN};
  - the default parameter constants WIDTH/ADDR_W/NREAD.
- One sub-module, reg_bank_scoreboard, holds the DEPTH-bit busy vector, set/clear priority, and the NREAD rd_busy lookups.
- The array, init FSM and read ports live in reg_bank.

## Test plan

- Reset then wait: ready=0 for 32 cycles, then 1. Reading all 32 addresses after that returns 0.
- Write wa=5, wd=0xDEADBEEF. Next cycle read ra={5,0} → rd_data port0=0xDEADBEEF, port1=0. Then write wa=0, wd=0x1234 and read 0 → 0.
- Same-cycle we wa=7 wd=0xA5A5A5A5 with re ra0=7 (old value 0x11):
  - with REG_BANK_BYPASS_EN → 0xA5A5A5A5;
  - without → 0x11. In both builds the following read returns 0xA5A5A5A5.
- Scoreboard sequence:
  - sb_set addr 9 → with ra0=9, rd_busy[0]=1 next cycle;
  - we wa=9 → rd_busy[0]=0 next cycle;
  - sb_set 9 together with we wa=9 in one cycle → rd_busy[0]=1.
- Assert rst mid-run after writing reg 3=0x77 with busy[3]=1: ready drops and busy clears next cycle. After re-init, read 3 → 0.
- re low for 4 cycles while writes change the array: rd_data holds its last read value unchanged.
